// File: rtl/sw_pkt_rr_sched.sv
// Packet-level round-robin scheduler: grants one ingress FIFO at a time,
// holds the grant until the packet's last word (or the length watchdog)
// terminates it, then rotates priority past the served FIFO.
module sw_pkt_rr_sched #(
  parameter int NUM_SW_INST = 5,
  parameter int MAX_PKT_LEN = 16,
  parameter int ID_W        = $clog2(NUM_SW_INST)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SW_INST-1:0] empty,
  input  logic [NUM_SW_INST-1:0] last,
  input  logic                   dst_busy,
  output logic [NUM_SW_INST-1:0] rd_en,
  output logic [ID_W-1:0]        grant_id,
  output logic                   pkt_active,
  output logic                   pkt_done,
  output logic                   err_overlen
);

  // beat_cnt must hold MAX_PKT_LEN after the final forced pop
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_vld;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pop;
  logic              term;
  logic              head_last;

  // Rotating-priority search: walk from the highest offset down so the
  // lowest offset from rr_ptr (highest priority) is the final assignment.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_SW_INST - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_SW_INST) idx = idx - NUM_SW_INST;
      if (!empty[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  // Pop only the locked FIFO, only when it has data and downstream is free.
  always_comb begin
    head_last = last[grant_id];
    pop       = (state == XFER) && !empty[grant_id] && !dst_busy;
    term      = pop && (head_last || (beat_cnt == CNT_W'(MAX_PKT_LEN - 1)));
  end

  // One-hot pop strobe decoded from the current grant.
  for (genvar g = 0; g < NUM_SW_INST; g++) begin : g_rd
    assign rd_en[g] = pop && (grant_id == ID_W'(g));
  end

  assign pkt_active = (state == XFER);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Next state: lock on a winner, release on a terminating pop.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (win_vld) state_nxt = XFER;
      XFER:    if (term)    state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grant, beat counter, priority pointer and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      pkt_done    <= 1'b0;
      err_overlen <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      err_overlen <= 1'b0;
      if (state == ARB) begin
        if (win_vld) begin
          grant_id <= win_id;
          beat_cnt <= '0;
        end
      end else if (pop) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (term) begin
          rr_ptr      <= (grant_id == ID_W'(NUM_SW_INST - 1)) ? '0 : grant_id + ID_W'(1);
          pkt_done    <= 1'b1;
          err_overlen <= !head_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_pkt_rr_sched.sv
// Scoreboarded random bench for sw_pkt_rr_sched. Ingress FIFOs are modelled
// as word arrays; a packet-level reference model predicts each cycle's
// outputs, which a separate monitor compares against the DUT.
module tb_sw_pkt_rr_sched;
  localparam int N    = 5;
  localparam int MAXL = 16;
  localparam int IDW  = $clog2(N);
  localparam int DEP  = 1024;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   empty = '1;
  logic [N-1:0]   last = '0;
  logic           dst_busy = 1'b0;
  logic [N-1:0]   rd_en;
  logic [IDW-1:0] grant_id;
  logic           pkt_active, pkt_done, err_overlen;

  sw_pkt_rr_sched #(.NUM_SW_INST(N), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .empty(empty), .last(last), .dst_busy(dst_busy),
    .rd_en(rd_en), .grant_id(grant_id), .pkt_active(pkt_active),
    .pkt_done(pkt_done), .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rd_en;
    logic         act;
    int           gid;
    logic         done;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // FIFO contents: one 'last' flag per word, circular storage
  bit mem [N][DEP];
  int hd [N];
  int tl [N];

  // Reference model: owner < 0 means no packet is locked
  int owner, ptr, cnt, gid_q;
  bit done_q, err_q;

  int len_tbl [8] = '{1, 2, 3, 5, MAXL - 1, MAXL, MAXL + 1, MAXL + 4};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pkt(int f, int len);
    for (int k = 0; k < len; k++) begin
      mem[f][tl[f] % DEP] = (k == len - 1);
      tl[f]++;
    end
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0; cnt = 0; gid_q = 0; done_q = 0; err_q = 0;
  endtask

  // One cycle: drive inputs, push the expected outputs, advance the model
  // across the coming clock edge.
  task automatic step(bit busy_en, bit hide_en, bit force_show, bit rst_v, bit refill);
    exp_t e;
    bit nd, ne, lw;
    @(posedge clk); #1;
    rst = rst_v;
    if (refill)
      for (int f = 0; f < N; f++)
        if (tl[f] - hd[f] < 4) push_pkt(f, len_tbl[$urandom_range(0, 7)]);
    for (int f = 0; f < N; f++) begin
      empty[f] = (hd[f] == tl[f]) ||
                 (hide_en && !force_show && $urandom_range(0, 3) == 0);
      last[f]  = (hd[f] != tl[f]) ? mem[f][hd[f] % DEP] : 1'($urandom);
    end
    dst_busy = busy_en && ($urandom_range(0, 2) == 0);

    e.rd_en = '0;
    if (owner >= 0 && !empty[owner] && !dst_busy) e.rd_en[owner] = 1'b1;
    e.act  = (owner >= 0);
    e.gid  = gid_q;
    e.done = done_q;
    e.err  = err_q;
    sb.push_back(e);

    if (!rst_v) begin
      nd = 0; ne = 0;
      if (owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (!empty[(ptr + k) % N]) begin
            owner = (ptr + k) % N; gid_q = owner; cnt = 0;
            break;
          end
        end
      end else if (!empty[owner] && !dst_busy) begin
        lw = mem[owner][hd[owner] % DEP];
        hd[owner]++;
        cnt++;
        if (lw || cnt == MAXL) begin
          nd = 1; ne = !lw; ptr = (owner + 1) % N; owner = -1;
        end
      end
      done_q = nd; err_q = ne;
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_en",       32'(rd_en),       32'(e.rd_en));
        chk("pkt_active",  32'(pkt_active),  32'(e.act));
        chk("grant_id",    32'(grant_id),    32'(e.gid));
        chk("pkt_done",    32'(pkt_done),    32'(e.done));
        chk("err_overlen", 32'(err_overlen), 32'(e.err));
      end
    end
  end

  initial begin
    bit reached;
    for (int f = 0; f < N; f++) begin hd[f] = 0; tl[f] = 0; end
    model_reset();

    // Reset state before any clock edge
    #1;
    chk("rst_rd_en",  32'(rd_en),       0);
    chk("rst_active", 32'(pkt_active),  0);
    chk("rst_gid",    32'(grant_id),    0);
    chk("rst_done",   32'(pkt_done),    0);
    chk("rst_err",    32'(err_overlen), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // All FIFOs backlogged with 3-word packets, no backpressure
    for (int f = 0; f < N; f++) begin push_pkt(f, 3); push_pkt(f, 3); end
    for (int n = 0; n < 45; n++) step(0, 0, 0, 0, 0);

    // Random traffic with stalls, backpressure and over-length packets
    for (int n = 0; n < 600; n++) step(1, 1, 0, 0, 1);

    // Reach the middle of a packet, then reset between clock edges
    reached = 0;
    for (int n = 0; n < 200 && !reached; n++) begin
      step(1, 1, 0, 0, 1);
      reached = (owner >= 0 && cnt > 0);
    end
    chk("midpkt_reach", 32'(reached), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rd_en",  32'(rd_en),      0);
    chk("async_active", 32'(pkt_active), 0);
    chk("async_gid",    32'(grant_id),   0);
    chk("async_done",   32'(pkt_done),   0);
    model_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Release with every FIFO non-empty: first grant must be FIFO 0
    step(0, 0, 1, 0, 1);
    for (int n = 0; n < 400; n++) step(1, 1, 0, 0, 1);

    // Let the monitor drain the scoreboard
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
